// File: rtl/inst_fetch_pkg.sv
// Shared fetch-stage types and constants: datapath widths, PC step, NOP encoding,
// and the queue entry layout pairing an instruction with its PC.
package inst_fetch_pkg;

  localparam int WORD      = 64;
  localparam int INST_SIZE = 32;
  localparam int PC_STEP   = 4;
  localparam logic [31:0] NOP = 32'hD503201F;

  typedef struct packed {
    logic [INST_SIZE-1:0] inst;
    logic [WORD-1:0]      pc;
  } if_entry_t;

  // Sequential next PC; wraps naturally at 2^WORD.
  function automatic logic [WORD-1:0] pc_next(input logic [WORD-1:0] pc);
    return pc + WORD'(PC_STEP);
  endfunction

endpackage

// File: rtl/inst_fetch_if.sv
// Fetch-stage bus bundle: imem request/response, decode handshake and redirect.
// With IF_MISALIGN_CHK_EN defined the bundle also carries fetch_misalign.
interface inst_fetch_if;
  import inst_fetch_pkg::*;

  logic                 imem_req_valid;
  logic                 imem_req_ready;
  logic [WORD-1:0]      imem_req_addr;
  logic                 imem_rsp_valid;
  logic [INST_SIZE-1:0] imem_rsp_data;
  logic                 inst_valid;
  logic                 inst_ready;
  logic [INST_SIZE-1:0] inst;
  logic [WORD-1:0]      inst_pc;
  logic                 redirect_valid;
  logic [WORD-1:0]      redirect_pc;
`ifdef IF_MISALIGN_CHK_EN
  logic                 fetch_misalign;

  modport master (
    output imem_req_valid, imem_req_addr, inst_valid, inst, inst_pc, fetch_misalign,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data, inst_ready, redirect_valid, redirect_pc
  );
  modport slave (
    input  imem_req_valid, imem_req_addr, inst_valid, inst, inst_pc, fetch_misalign,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data, inst_ready, redirect_valid, redirect_pc
  );
`else
  modport master (
    output imem_req_valid, imem_req_addr, inst_valid, inst, inst_pc,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data, inst_ready, redirect_valid, redirect_pc
  );
  modport slave (
    input  imem_req_valid, imem_req_addr, inst_valid, inst, inst_pc,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data, inst_ready, redirect_valid, redirect_pc
  );
`endif

endinterface

// File: rtl/inst_fetch_fifo.sv
// Small synchronous FIFO (power-of-2 depth) with flush; used for the fetch
// instruction queue and the in-flight PC shadow. Flush/reset override push/pop.
module fetch_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_flush,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [WIDTH-1:0] i_din,
  output logic [WIDTH-1:0] o_head,
  output logic [CW-1:0]    o_count,
  output logic             o_empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_push_ok;
  logic             w_pop_ok;

  assign w_pop_ok  = i_pop && (r_count != '0);
  assign w_push_ok = i_push && ((r_count != CW'(DEPTH)) || w_pop_ok);

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge i_clk) begin
    if (i_rst || i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count <= r_count + CW'(w_push_ok) - CW'(w_pop_ok);
    end
  end

  // Storage write; contents need no reset since occupancy gates every read.
  always_ff @(posedge i_clk) begin
    if (w_push_ok && !i_flush && !i_rst) r_mem[r_wr_ptr] <= i_din;
  end

  assign o_head  = r_mem[r_rd_ptr];
  assign o_count = r_count;
  assign o_empty = (r_count == '0);

endmodule

// File: rtl/inst_fetch.sv
// Instruction-fetch stage: owns the PC, issues in-order imem requests under a
// credit limit, queues returned instructions with their PC for decode, and
// squashes queue plus in-flight fetches on an EX redirect.
// Optional: IF_MISALIGN_CHK_EN rejects redirects to non-word-aligned targets
// and pulses fetch_misalign; otherwise the target's low two bits are cleared.
module inst_fetch
  import inst_fetch_pkg::*;
#(
  parameter logic [WORD-1:0] RESET_PC = '0,
  parameter int              FQ_DEPTH = 2
) (
  input logic         clk,
  input logic         rst,
  inst_fetch_if.master bus
);

  localparam int CW = $clog2(FQ_DEPTH) + 1;

  logic [WORD-1:0] r_pc;
  logic [CW-1:0]   r_drop_cnt;

  logic [CW-1:0]   w_q_count;
  logic            w_q_empty;
  if_entry_t       w_q_head;
  if_entry_t       w_q_din;
  logic            w_q_push;
  logic            w_q_pop;

  logic [CW-1:0]   w_inflight;
  logic            w_sh_empty;
  logic [WORD-1:0] w_sh_head;

  logic [CW:0]     w_occ;
  logic            w_req_valid;
  logic            w_req_fire;
  logic            w_rsp_fire;
  logic            w_drop;
  logic            w_redir_take;
  logic [WORD-1:0] w_redir_pc;

  // A decode pop in the same cycle frees its slot, so depth 2 sustains one
  // instruction per cycle against a 1-cycle memory.
  assign w_q_pop     = !w_q_empty && bus.inst_ready;
  assign w_occ       = {1'b0, w_q_count} + {1'b0, w_inflight} - (CW+1)'(w_q_pop);
  assign w_req_valid = !rst && (w_occ < (CW+1)'(FQ_DEPTH)) && !bus.redirect_valid;
  assign w_req_fire  = w_req_valid && bus.imem_req_ready;

  // Responses with nothing outstanding are leftovers from before reset.
  assign w_rsp_fire  = bus.imem_rsp_valid && !w_sh_empty;
  assign w_drop      = w_rsp_fire && (r_drop_cnt != '0);
  assign w_q_push    = w_rsp_fire && !w_drop;
  assign w_q_din     = '{inst: bus.imem_rsp_data, pc: w_sh_head};

`ifdef IF_MISALIGN_CHK_EN
  logic r_fetch_misalign;
  assign w_redir_take = bus.redirect_valid && (bus.redirect_pc[1:0] == 2'b00);
  assign w_redir_pc   = bus.redirect_pc;

  // One-cycle flag for a rejected misaligned redirect.
  always_ff @(posedge clk) begin
    if (rst) r_fetch_misalign <= 1'b0;
    else     r_fetch_misalign <= bus.redirect_valid && (bus.redirect_pc[1:0] != 2'b00);
  end
  assign bus.fetch_misalign = r_fetch_misalign;
`else
  assign w_redir_take = bus.redirect_valid;
  assign w_redir_pc   = bus.redirect_pc & ~WORD'(3);
`endif

  fetch_fifo #(.WIDTH($bits(if_entry_t)), .DEPTH(FQ_DEPTH)) u_inst_q (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_flush (w_redir_take),
    .i_push  (w_q_push),
    .i_pop   (w_q_pop),
    .i_din   (w_q_din),
    .o_head  (w_q_head),
    .o_count (w_q_count),
    .o_empty (w_q_empty)
  );

  // Not flushed on redirect: squashed requests still return and must pop it.
  fetch_fifo #(.WIDTH(WORD), .DEPTH(FQ_DEPTH)) u_pc_shadow (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_flush (1'b0),
    .i_push  (w_req_fire),
    .i_pop   (w_rsp_fire),
    .i_din   (r_pc),
    .o_head  (w_sh_head),
    .o_count (w_inflight),
    .o_empty (w_sh_empty)
  );

  // PC advance and squash counter; redirect wins over everything else.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc       <= RESET_PC;
      r_drop_cnt <= '0;
    end else if (w_redir_take) begin
      r_pc       <= w_redir_pc;
      r_drop_cnt <= w_inflight - CW'(w_rsp_fire);
    end else begin
      if (w_req_fire) r_pc <= pc_next(r_pc);
      if (w_drop)     r_drop_cnt <= r_drop_cnt - CW'(1);
    end
  end

  assign bus.imem_req_valid = w_req_valid;
  assign bus.imem_req_addr  = r_pc;
  assign bus.inst_valid     = !w_q_empty;
  assign bus.inst           = w_q_empty ? '0 : w_q_head.inst;
  assign bus.inst_pc        = w_q_empty ? '0 : w_q_head.pc;

endmodule
